conv_mac_engine: RTL and testbench
==================================

Name: conv_mac_engine

Overview:
- Datapath stage directly downstream of the convolution control unit.
- Holds the X sample memory, which is written with the same write-enable and address the control unit produces.
- Holds the F coefficient memory, which is loaded through its own valid/ready port.
- On each accepted window request, computes y = sum over i of f[i]*x[(base+i) mod X_MEM_SIZE] with one sequential MAC per cycle, then presents y on a valid/ready output.

Parameters:
F_MEM_SIZE, 4, number of filter taps (power of two)
X_MEM_SIZE, 8, depth of X sample memory (power of two)
X_MEM_ADDR_WIDTH, 3, log2(X_MEM_SIZE)
F_MEM_ADDR_WIDTH, 2, log2(F_MEM_SIZE)
DATA_WIDTH, 8, signed width of x and f samples

Ports:
clk  in  1  clock, all state on rising edge
reset  in  1  asynchronous, active-low reset (0 = reset asserted)
x_wr_en  in  1  write strobe for X memory (control unit mem_wr_en)
x_wr_addr  in  X_MEM_ADDR_WIDTH  X write address (low bits of control unit x_count)
x_wr_data  in  DATA_WIDTH  signed sample written to X
s_data_f  in  DATA_WIDTH  signed coefficient
s_valid_f  in  1  coefficient valid
s_ready_f  out  1  coefficient ready
f_clear  in  1  pulse: discard coefficients and reload
s_valid_win  in  1  window request valid
s_ready_win  out  1  window request ready
win_base  in  X_MEM_ADDR_WIDTH  first X index of window
m_data_y  out  Y_WIDTH  signed result, Y_WIDTH = 2*DATA_WIDTH+F_MEM_ADDR_WIDTH
m_valid_y  out  1  result valid
m_ready_y  in  1  result ready

Behaviour:
- Reset (reset=0, async) outputs:
  - s_ready_f=0, s_ready_win=0, m_valid_y=0, m_data_y=0.
  - State=LOAD_F, f_cnt=0, tap=0, acc=0.
  - X/F memory contents are not reset.
- All ready/valid outputs are registered.
- First rising edge after reset release: s_ready_f=1.
- Reset asserted mid-operation aborts immediately; any result in flight is lost.
- X writes:
  - Any state: x_wr_en=1 writes x_wr_data to x_mem[x_wr_addr] at the clock edge. No backpressure.
  - A read in the same cycle returns the old value.
- FSM states: LOAD_F, IDLE, MAC, OUT.
- LOAD_F:
  - s_ready_f=1. Each s_valid_f&s_ready_f writes f_mem[f_cnt] and increments f_cnt.
  - When the F_MEM_SIZE-th coefficient is accepted: s_ready_f<=0, s_ready_win<=1, go to IDLE.
  - f_clear=1: f_cnt<=0, stay in LOAD_F.
- IDLE:
  - s_ready_win=1.
  - f_clear=1: go to LOAD_F, f_cnt<=0, s_ready_win<=0.
  - f_clear has priority over a simultaneous window handshake; the window is not accepted.
  - Else s_valid_win=1: latch base<=win_base, tap<=0, acc<=0, s_ready_win<=0, go to MAC.
- MAC:
  - Each cycle: acc<=acc+sext(f_mem[tap]*x_mem[(base+tap) mod X_MEM_SIZE]).
  - Product is a full signed 2*DATA_WIDTH value; acc is Y_WIDTH, no saturation (Y_WIDTH cannot overflow).
  - tap increments. After the tap==F_MEM_SIZE-1 cycle: m_data_y<=final sum, m_valid_y<=1, go to OUT.
  - f_clear is ignored in MAC and OUT.
- OUT:
  - m_valid_y=1, m_data_y stable until m_ready_y=1.
  - On handshake: m_valid_y<=0, s_ready_win<=1, go to IDLE.
- Latency: window handshake in cycle T -> m_valid_y=1 in cycle T+F_MEM_SIZE+1.
- Throughput: one result per F_MEM_SIZE+2 cycles when m_ready_y is held at 1.
- Wrap: window index is (base+tap) truncated to X_MEM_ADDR_WIDTH bits.

Decomposition:
- Package conv_pkg:
  - typedef enum {LOAD_F, IDLE, MAC, OUT} mac_state_t.
  - Localparam/function for Y_WIDTH.
  - Shared defaults for DATA_WIDTH, F_MEM_SIZE, X_MEM_SIZE.
- One sub-module, conv_regfile:
  - Parameterised depth/width.
  - One synchronous write port, one combinational read port.
  - Instantiated twice, for X and F.

Test Plan:
- Load f={1,2,3,4}, write x[0..7]={1..8}, window base=0, m_ready_y=1 -> m_data_y=30, m_valid_y high exactly 5 cycles after the window handshake.
- Same data, base=6 -> reads x[6],x[7],x[0],x[1]; m_data_y=1*7+2*8+3*1+4*2=34.
- f all -128, x all -128, base=0 -> m_data_y=65536 (18-bit signed, no overflow). f={-1,-1,-1,-1}, x={127,...} -> m_data_y=-508.
- Backpressure: m_ready_y=0 for 3 cycles in OUT while x_wr_en rewrites x -> m_data_y unchanged, s_ready_win=0; m_ready_y=1 -> next cycle m_valid_y=0, s_ready_win=1.
- f_clear asserted in IDLE together with s_valid_win -> window not accepted, s_ready_f=1. Reload f={0,0,0,1}, base=2 -> m_data_y=x[5]=6. f_clear pulsed during MAC -> ignored, result unchanged.
- Reset (0) asserted mid-MAC -> m_valid_y=0 asynchronously, s_ready_f=1 after release, f must be reloaded before the next window is accepted.

Source files
------------

// File: rtl/conv_pkg.sv
// Shared types and defaults for the convolution MAC datapath.
package conv_pkg;

  localparam int unsigned DefDataWidth = 8;
  localparam int unsigned DefFMemSize  = 4;
  localparam int unsigned DefXMemSize  = 8;

  typedef enum logic [1:0] {LOAD_F, IDLE, MAC, OUT} mac_state_t;

  // Accumulator width: full product plus headroom for F_MEM_SIZE additions.
  function automatic int unsigned y_width(input int unsigned data_width,
                                          input int unsigned f_addr_width);
    return 2 * data_width + f_addr_width;
  endfunction

endpackage

// File: rtl/conv_regfile.sv
// Small register file: one synchronous write port, one combinational read port.
module conv_regfile #(
  parameter int unsigned Depth     = 8,
  parameter int unsigned Width     = 8,
  parameter int unsigned AddrWidth = $clog2(Depth)
) (
  input  logic                 clk,
  input  logic                 wr_en,
  input  logic [AddrWidth-1:0] wr_addr,
  input  logic [Width-1:0]     wr_data,
  input  logic [AddrWidth-1:0] rd_addr,
  output logic [Width-1:0]     rd_data
);

  logic [Width-1:0] mem_q [Depth];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

  // Same-cycle read of a written address returns the pre-write contents.
  assign rd_data = mem_q[rd_addr];

endmodule

// File: rtl/conv_mac_engine.sv
// Convolution MAC stage: X/F memories plus a sequential one-tap-per-cycle
// multiply-accumulate with valid/ready coefficient, window and result ports.
module conv_mac_engine
  import conv_pkg::*;
#(
  parameter int unsigned F_MEM_SIZE       = DefFMemSize,
  parameter int unsigned X_MEM_SIZE       = DefXMemSize,
  parameter int unsigned X_MEM_ADDR_WIDTH = $clog2(X_MEM_SIZE),
  parameter int unsigned F_MEM_ADDR_WIDTH = $clog2(F_MEM_SIZE),
  parameter int unsigned DATA_WIDTH       = DefDataWidth,
  parameter int unsigned Y_WIDTH          = y_width(DATA_WIDTH, F_MEM_ADDR_WIDTH)
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        x_wr_en,
  input  logic [X_MEM_ADDR_WIDTH-1:0] x_wr_addr,
  input  logic [DATA_WIDTH-1:0]       x_wr_data,
  input  logic [DATA_WIDTH-1:0]       s_data_f,
  input  logic                        s_valid_f,
  output logic                        s_ready_f,
  input  logic                        f_clear,
  input  logic                        s_valid_win,
  output logic                        s_ready_win,
  input  logic [X_MEM_ADDR_WIDTH-1:0] win_base,
  output logic [Y_WIDTH-1:0]          m_data_y,
  output logic                        m_valid_y,
  input  logic                        m_ready_y
);

  localparam logic [F_MEM_ADDR_WIDTH-1:0] FLast = F_MEM_ADDR_WIDTH'(F_MEM_SIZE - 1);

  mac_state_t                    state_q, state_d;
  logic [F_MEM_ADDR_WIDTH-1:0]   f_cnt_q, f_cnt_d;
  logic [F_MEM_ADDR_WIDTH-1:0]   tap_q, tap_d;
  logic [X_MEM_ADDR_WIDTH-1:0]   base_q, base_d;
  logic signed [Y_WIDTH-1:0]     acc_q, acc_d;
  logic [Y_WIDTH-1:0]            m_data_y_q, m_data_y_d;
  logic                          s_ready_f_q, s_ready_f_d;
  logic                          s_ready_win_q, s_ready_win_d;
  logic                          m_valid_y_q, m_valid_y_d;
  logic                          f_wr_en;

  logic [X_MEM_ADDR_WIDTH-1:0]   x_rd_addr;
  logic [DATA_WIDTH-1:0]         x_rd_data;
  logic [DATA_WIDTH-1:0]         f_rd_data;
  logic signed [2*DATA_WIDTH-1:0] prod;

  conv_regfile #(
    .Depth     (X_MEM_SIZE),
    .Width     (DATA_WIDTH),
    .AddrWidth (X_MEM_ADDR_WIDTH)
  ) u_x_mem (
    .clk     (clk),
    .wr_en   (x_wr_en),
    .wr_addr (x_wr_addr),
    .wr_data (x_wr_data),
    .rd_addr (x_rd_addr),
    .rd_data (x_rd_data)
  );

  conv_regfile #(
    .Depth     (F_MEM_SIZE),
    .Width     (DATA_WIDTH),
    .AddrWidth (F_MEM_ADDR_WIDTH)
  ) u_f_mem (
    .clk     (clk),
    .wr_en   (f_wr_en),
    .wr_addr (f_cnt_q),
    .wr_data (s_data_f),
    .rd_addr (tap_q),
    .rd_data (f_rd_data)
  );

  // Window index wraps modulo X_MEM_SIZE by truncation.
  assign x_rd_addr = base_q + X_MEM_ADDR_WIDTH'(tap_q);
  assign prod      = $signed(f_rd_data) * $signed(x_rd_data);

  always_comb begin
    state_d       = state_q;
    f_cnt_d       = f_cnt_q;
    tap_d         = tap_q;
    base_d        = base_q;
    acc_d         = acc_q;
    m_data_y_d    = m_data_y_q;
    s_ready_f_d   = s_ready_f_q;
    s_ready_win_d = s_ready_win_q;
    m_valid_y_d   = m_valid_y_q;
    f_wr_en       = 1'b0;
    unique case (state_q)
      LOAD_F: begin
        s_ready_f_d = 1'b1;
        if (f_clear) begin
          f_cnt_d = '0;
        end else if (s_valid_f && s_ready_f_q) begin
          f_wr_en = 1'b1;
          f_cnt_d = f_cnt_q + 1'b1;
          if (f_cnt_q == FLast) begin
            s_ready_f_d   = 1'b0;
            s_ready_win_d = 1'b1;
            state_d       = IDLE;
          end
        end
      end
      IDLE: begin
        // A clear wins over a simultaneous window request.
        if (f_clear) begin
          f_cnt_d       = '0;
          s_ready_win_d = 1'b0;
          s_ready_f_d   = 1'b1;
          state_d       = LOAD_F;
        end else if (s_valid_win && s_ready_win_q) begin
          base_d        = win_base;
          tap_d         = '0;
          acc_d         = '0;
          s_ready_win_d = 1'b0;
          state_d       = MAC;
        end
      end
      MAC: begin
        acc_d = acc_q + Y_WIDTH'(prod);
        tap_d = tap_q + 1'b1;
        if (tap_q == FLast) begin
          m_data_y_d  = acc_d;
          m_valid_y_d = 1'b1;
          state_d     = OUT;
        end
      end
      OUT: begin
        if (m_ready_y) begin
          m_valid_y_d   = 1'b0;
          s_ready_win_d = 1'b1;
          state_d       = IDLE;
        end
      end
      default: state_d = LOAD_F;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= LOAD_F;
      f_cnt_q       <= '0;
      tap_q         <= '0;
      base_q        <= '0;
      acc_q         <= '0;
      m_data_y_q    <= '0;
      s_ready_f_q   <= 1'b0;
      s_ready_win_q <= 1'b0;
      m_valid_y_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      f_cnt_q       <= f_cnt_d;
      tap_q         <= tap_d;
      base_q        <= base_d;
      acc_q         <= acc_d;
      m_data_y_q    <= m_data_y_d;
      s_ready_f_q   <= s_ready_f_d;
      s_ready_win_q <= s_ready_win_d;
      m_valid_y_q   <= m_valid_y_d;
    end
  end

  assign s_ready_f   = s_ready_f_q;
  assign s_ready_win = s_ready_win_q;
  assign m_valid_y   = m_valid_y_q;
  assign m_data_y    = m_data_y_q;

endmodule

// File: tb/tb_conv_mac_engine.sv
// Directed-vector bench for conv_mac_engine; inputs change and outputs are sampled on negedges.
module tb_conv_mac_engine;

  logic        clk = 1'b0;
  logic        reset;
  logic        x_wr_en;
  logic [2:0]  x_wr_addr;
  logic [7:0]  x_wr_data;
  logic [7:0]  s_data_f;
  logic        s_valid_f;
  logic        s_ready_f;
  logic        f_clear;
  logic        s_valid_win;
  logic        s_ready_win;
  logic [2:0]  win_base;
  logic [17:0] m_data_y;
  logic        m_valid_y;
  logic        m_ready_y;

  int n_vec = 0;
  int n_err = 0;

  conv_mac_engine dut (
    .clk         (clk),
    .reset       (reset),
    .x_wr_en     (x_wr_en),
    .x_wr_addr   (x_wr_addr),
    .x_wr_data   (x_wr_data),
    .s_data_f    (s_data_f),
    .s_valid_f   (s_valid_f),
    .s_ready_f   (s_ready_f),
    .f_clear     (f_clear),
    .s_valid_win (s_valid_win),
    .s_ready_win (s_ready_win),
    .win_base    (win_base),
    .m_data_y    (m_data_y),
    .m_valid_y   (m_valid_y),
    .m_ready_y   (m_ready_y)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic signed [31:0] got,
                          input logic signed [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic wait_rdy_f();
    int n = 0;
    while (s_ready_f !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (s_ready_f !== 1'b1) check_eq("s_ready_f timeout", 0, 1);
  endtask

  task automatic wait_rdy_win();
    int n = 0;
    while (s_ready_win !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (s_ready_win !== 1'b1) check_eq("s_ready_win timeout", 0, 1);
  endtask

  task automatic write_x(input int addr, input int data);
    x_wr_en   = 1'b1;
    x_wr_addr = 3'(addr);
    x_wr_data = 8'(data);
    @(negedge clk);
    x_wr_en   = 1'b0;
  endtask

  task automatic load_f(input int c0, input int c1, input int c2, input int c3);
    int c[4] = '{c0, c1, c2, c3};
    for (int i = 0; i < 4; i++) begin
      wait_rdy_f();
      s_valid_f = 1'b1;
      s_data_f  = 8'(c[i]);
      @(negedge clk);
      s_valid_f = 1'b0;
    end
  endtask

  task automatic pulse_clear();
    f_clear = 1'b1;
    @(negedge clk);
    f_clear = 1'b0;
  endtask

  // Issues one window, checks latency and result; if m_ready_y is high also
  // checks the output handshake. clear_at>0 pulses f_clear during MAC.
  task automatic run_window(input int base, input int exp, input string tag,
                            input int clear_at);
    int n;
    wait_rdy_win();
    s_valid_win = 1'b1;
    win_base    = 3'(base);
    @(negedge clk);
    s_valid_win = 1'b0;
    n = 1;
    while (m_valid_y !== 1'b1 && n < 20) begin
      if (n == clear_at) f_clear = 1'b1;
      @(negedge clk);
      f_clear = 1'b0;
      n++;
    end
    check_eq({tag, " latency"}, n, 5);
    check_eq({tag, " data"}, $signed(m_data_y), exp);
    if (m_ready_y) begin
      @(negedge clk);
      check_eq({tag, " m_valid_y drop"}, m_valid_y, 0);
      check_eq({tag, " s_ready_win back"}, s_ready_win, 1);
    end
  endtask

  initial begin
    reset = 1'b0; x_wr_en = 1'b0; x_wr_addr = '0; x_wr_data = '0;
    s_data_f = '0; s_valid_f = 1'b0; f_clear = 1'b0;
    s_valid_win = 1'b0; win_base = '0; m_ready_y = 1'b1;
    #12;
    check_eq("rst s_ready_f", s_ready_f, 0);
    check_eq("rst s_ready_win", s_ready_win, 0);
    check_eq("rst m_valid_y", m_valid_y, 0);
    check_eq("rst m_data_y", $signed(m_data_y), 0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check_eq("post-rst s_ready_f", s_ready_f, 1);
    check_eq("post-rst s_ready_win", s_ready_win, 0);

    for (int i = 0; i < 8; i++) write_x(i, i + 1);
    load_f(1, 2, 3, 4);
    check_eq("loaded s_ready_f", s_ready_f, 0);
    check_eq("loaded s_ready_win", s_ready_win, 1);
    run_window(0, 30, "base0", 0);
    run_window(6, 34, "wrap6", 0);

    // Clear together with a window request: clear wins.
    f_clear = 1'b1; s_valid_win = 1'b1; win_base = 3'd0;
    @(negedge clk);
    f_clear = 1'b0; s_valid_win = 1'b0;
    check_eq("clr s_ready_f", s_ready_f, 1);
    check_eq("clr s_ready_win", s_ready_win, 0);
    repeat (4) @(negedge clk);
    check_eq("clr no window", m_valid_y, 0);

    for (int i = 0; i < 8; i++) write_x(i, -128);
    load_f(-128, -128, -128, -128);
    run_window(0, 65536, "maxneg", 0);

    pulse_clear();
    for (int i = 0; i < 8; i++) write_x(i, 127);
    load_f(-1, -1, -1, -1);
    run_window(0, -508, "neg", 0);

    pulse_clear();
    for (int i = 0; i < 8; i++) write_x(i, i + 1);
    load_f(0, 0, 0, 1);
    run_window(2, 6, "tap3", 0);

    // Backpressure while X is rewritten underneath.
    m_ready_y = 1'b0;
    run_window(2, 6, "bp", 0);
    write_x(5, 100);
    check_eq("bp hold data 1", $signed(m_data_y), 6);
    check_eq("bp hold valid 1", m_valid_y, 1);
    check_eq("bp win busy 1", s_ready_win, 0);
    write_x(6, 9);
    check_eq("bp hold data 2", $signed(m_data_y), 6);
    write_x(7, 10);
    check_eq("bp hold data 3", $signed(m_data_y), 6);
    check_eq("bp win busy 3", s_ready_win, 0);
    m_ready_y = 1'b1;
    @(negedge clk);
    check_eq("bp release valid", m_valid_y, 0);
    check_eq("bp release win", s_ready_win, 1);

    run_window(2, 100, "xnew", 0);
    run_window(2, 100, "clr_in_mac", 2);
    check_eq("clr_in_mac s_ready_f", s_ready_f, 0);

    // Reset mid-MAC.
    wait_rdy_win();
    s_valid_win = 1'b1; win_base = 3'd0;
    @(negedge clk);
    s_valid_win = 1'b0;
    @(negedge clk);
    #2 reset = 1'b0;
    #1;
    check_eq("midrst m_valid_y", m_valid_y, 0);
    check_eq("midrst m_data_y", $signed(m_data_y), 0);
    check_eq("midrst s_ready_f", s_ready_f, 0);
    check_eq("midrst s_ready_win", s_ready_win, 0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check_eq("rerst s_ready_f", s_ready_f, 1);
    check_eq("rerst s_ready_win", s_ready_win, 0);
    m_ready_y = 1'b0;
    s_valid_win = 1'b1; win_base = 3'd0;
    repeat (7) @(negedge clk);
    check_eq("rerst no window", m_valid_y, 0);
    check_eq("rerst win blocked", s_ready_win, 0);
    s_valid_win = 1'b0;
    m_ready_y = 1'b1;
    load_f(1, 2, 3, 4);
    run_window(5, 152, "post_rst", 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
